pc_redirect_unit: RTL
=====================

# pc_redirect_unit

Next-PC register and redirect controller for the 5-stage pipelined CPU. It consumes the 2-bit `NextType` decision produced by the EX-stage branch/jump detector and the ID-stage static predict-taken request. It owns the architectural fetch PC and drives the instruction-fetch handshake. It also raises the IF/ID and ID/EX flushes that squash wrong-path instructions.

## Interface
- RESET_PC, 32'h0000_3000: PC value loaded on reset.
- Ports: one clock; reset is asynchronous and active-low.
- clk  in  1  pipeline clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- stall  in  1  load-use hazard hold from hazard unit.
- next_type  in  2  EX decision: 00 PC+4, 01 branch predicted right, 10 mispredict, 11 jump.
- idex_pc_plus4  in  32  PC+4 of the branch currently in EX (mispredict recovery address).
- jump_target  in  32  jump target of the instruction in EX.
- id_branch  in  1  instruction in ID is a conditional branch (predicted taken).
- id_branch_target  in  32  branch target computed in ID.
- if_ready  in  1  instruction memory accepts the fetch at `pc` this cycle.
- pc  out  32  current fetch address.
- if_valid  out  1  fetch request valid.
- flush_ifid  out  1  clear IF/ID this edge.
- flush_idex  out  1  clear ID/EX this edge.

## Operation
- FSM states: BOOT, RUN, REDIRECT.
- Reset: `pc`=RESET_PC, state=BOOT, if_valid=0, flush_ifid=0, flush_idex=0, counters=0.
- BOOT: one cycle, no fetch; then RUN unconditionally.
- RUN: if_valid=1.
- REDIRECT: if_valid=1; wrong-path ID prediction is ignored. Next state is RUN unless a new redirect occurs.
- Redirect = next_type==10 or 11. Redirect priority, high to low:
  - next_type==10: pc<=idex_pc_plus4, flush_ifid=1, flush_idex=1, state<=REDIRECT.
  - next_type==11: pc<=jump_target, flush_ifid=1, flush_idex=1, state<=REDIRECT.
  - id_branch && state==RUN: pc<=id_branch_target; flush_ifid=1, flush_idex=0.
  - otherwise: pc<=pc+4, with 32-bit wrap (FFFF_FFFC+4 -> 0).
- next_type==01 and 00 are never redirects; they follow the lower rows.
- Advance condition for non-redirect rows: if_ready && !stall; otherwise pc holds and no flush.
- Redirects override both stall and !if_ready, because the outstanding fetch is wrong-path and is abandoned.
- Flush outputs are Mealy: combinational from current inputs and state, valid in the same cycle as the redirect.
- Redirect while in REDIRECT: taken again; state stays REDIRECT for one more cycle.
- Redirect while in BOOT: ignored (pipeline empty).

## Timing
- pc update latency: 1 cycle, at the edge ending the decision cycle.
- Mispredict penalty: 2 cycles (IF/ID and ID/EX squashed).
- Predicted-taken penalty: 1 cycle (IF/ID squashed).
- Reset mid-operation: immediate return to reset values regardless of state; flushes deassert asynchronously.
- if_valid is registered-state-derived only, with no combinational path from if_ready.

## Configuration
- PC_REDIRECT_PERF_EN defined: adds outputs mispredict_cnt[31:0], jump_cnt[31:0], predict_cnt[31:0].
  - Each counter increments by 1 on its accepted event: row 10, row 11, or taken ID prediction.
  - Counters saturate at FFFF_FFFF and reset to 0.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

## Structure
- Shared package/header: NextType encodings (NT_PLUS4=00, NT_BR_OK=01, NT_MISPRED=10, NT_JUMP=11), FSM state encodings, RESET_PC default.
- One sub-module: pc_redirect_perf, instantiated only under PC_REDIRECT_PERF_EN.

## Test plan
- Reset then release with if_ready=1: pc=0000_3000 for 2 cycles (BOOT, if_valid=0), then 3004, 3008.
- id_branch=1, target=3100 at pc=3008: next pc=3100, flush_ifid=1, flush_idex=0. Next cycle next_type=10, idex_pc_plus4=300C: pc=300C, both flushes=1, state REDIRECT.
- next_type=11, jump_target=4000 while stall=1 and if_ready=0: pc=4000 next cycle, both flushes=1.
- stall=1 for 3 cycles at pc=3010 with no redirect: pc holds 3010, no flush; then resumes at 3014.
- pc=FFFF_FFFC with PC+4 advance: wraps to 0000_0000. Also assert rstn low mid-REDIRECT: pc=3000 and flushes=0 immediately.
- With PC_REDIRECT_PERF_EN: 3 mispredicts, 2 jumps, 1 prediction -> counts 3/2/1; preload mispredict_cnt to FFFF_FFFF, one more mispredict -> stays FFFF_FFFF.

Source files
------------

// File: rtl/pc_redirect_unit_pkg.sv
// rtl/pc_redirect_unit_pkg.sv - shared encodings and constants for the next-PC redirect unit
package pc_redirect_unit_pkg;

    typedef enum logic [1:0] {
        NT_PLUS4   = 2'b00,
        NT_BR_OK   = 2'b01,
        NT_MISPRED = 2'b10,
        NT_JUMP    = 2'b11
    } next_type_e;

    typedef enum logic [1:0] {
        ST_BOOT     = 2'b00,
        ST_RUN      = 2'b01,
        ST_REDIRECT = 2'b10
    } pc_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

    // Sequential fetch address; wraps naturally at the top of the 32-bit space.
    function automatic logic [31:0] pc_plus4(input logic [31:0] pc_cur);
        return pc_cur + 32'd4;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] cnt);
        return (cnt == 32'hFFFF_FFFF) ? cnt : cnt + 32'd1;
    endfunction

endpackage

// File: rtl/pc_redirect_perf.sv
// rtl/pc_redirect_perf.sv - saturating event counters for mispredicts, jumps and taken ID predictions
module pc_redirect_perf
    import pc_redirect_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        ev_mispred,
    input  logic        ev_jump,
    input  logic        ev_predict,
    output logic [31:0] mispredict_cnt,
    output logic [31:0] jump_cnt,
    output logic [31:0] predict_cnt
);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mispredict_cnt <= 32'd0;
            jump_cnt       <= 32'd0;
            predict_cnt    <= 32'd0;
        end else begin
            if (ev_mispred) begin
                mispredict_cnt <= sat_inc(mispredict_cnt);
            end
            if (ev_jump) begin
                jump_cnt <= sat_inc(jump_cnt);
            end
            if (ev_predict) begin
                predict_cnt <= sat_inc(predict_cnt);
            end
        end
    end

endmodule

// File: rtl/pc_redirect_unit.sv
// rtl/pc_redirect_unit.sv - fetch PC register, redirect FSM and IF/ID, ID/EX flush generation
// Optional performance counters are enabled with PC_REDIRECT_PERF_EN.
module pc_redirect_unit
    import pc_redirect_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        stall,
    input  logic [1:0]  next_type,
    input  logic [31:0] idex_pc_plus4,
    input  logic [31:0] jump_target,
    input  logic        id_branch,
    input  logic [31:0] id_branch_target,
    input  logic        if_ready,
`ifdef PC_REDIRECT_PERF_EN
    output logic [31:0] mispredict_cnt,
    output logic [31:0] jump_cnt,
    output logic [31:0] predict_cnt,
`endif
    output logic [31:0] pc,
    output logic        if_valid,
    output logic        flush_ifid,
    output logic        flush_idex
);

    pc_state_e   state;
    pc_state_e   state_next;
    next_type_e  nt;
    logic        is_live;
    logic        advance;
    logic        take_mispred;
    logic        take_jump;
    logic        redirect;
    logic        take_predict;
    logic [31:0] pc_next;

    assign nt = next_type_e'(next_type);

    // Event decode. Nothing is in flight during BOOT, so EX decisions are ignored there.
    always_comb begin
        is_live      = (state != ST_BOOT);
        advance      = if_ready && !stall;
        take_mispred = is_live && (nt == NT_MISPRED);
        take_jump    = is_live && (nt == NT_JUMP);
        redirect     = take_mispred || take_jump;
        take_predict = (state == ST_RUN) && !redirect && id_branch && advance;
    end

    // Redirects bypass stall/if_ready: the outstanding fetch is wrong-path anyway.
    always_comb begin
        pc_next = pc;
        if (take_mispred) begin
            pc_next = idex_pc_plus4;
        end else if (take_jump) begin
            pc_next = jump_target;
        end else if (take_predict) begin
            pc_next = id_branch_target;
        end else if (is_live && advance) begin
            pc_next = pc_plus4(pc);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_next;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_BOOT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_BOOT:     state_next = ST_RUN;
            ST_RUN:      state_next = redirect ? ST_REDIRECT : ST_RUN;
            ST_REDIRECT: state_next = redirect ? ST_REDIRECT : ST_RUN;
            default:     state_next = ST_BOOT;
        endcase
    end

    // if_valid depends on registered state only; flushes are Mealy on the same-cycle decision.
    always_comb begin
        if_valid   = (state == ST_RUN) || (state == ST_REDIRECT);
        flush_ifid = redirect || take_predict;
        flush_idex = redirect;
    end

`ifdef PC_REDIRECT_PERF_EN
    pc_redirect_perf u_perf (
        .clk            (clk),
        .rstn           (rstn),
        .ev_mispred     (take_mispred),
        .ev_jump        (take_jump),
        .ev_predict     (take_predict),
        .mispredict_cnt (mispredict_cnt),
        .jump_cnt       (jump_cnt),
        .predict_cnt    (predict_cnt)
    );
`endif

endmodule
